// File: rtl/rps_match_scorer_if.sv
// Handshake and status bundle between the round judge side and the match scorer.
// The master drives start and the round results; the slave returns ready and the match state.
interface rps_match_scorer_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               result_valid;
  logic [7:0]         result;
  logic               result_ready;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [7:0]         tie_cnt;
  logic [7:0]         inv_cnt;
  logic [7:0]         round_cnt;
  logic               match_over;
  logic [1:0]         match_winner;
  logic [7:0]         match_code;
  logic               done_pulse;

  modport master (
    output start, result_valid, result,
    input  result_ready, p1_score, p2_score, tie_cnt, inv_cnt, round_cnt,
           match_over, match_winner, match_code, done_pulse
  );

  modport slave (
    input  start, result_valid, result,
    output result_ready, p1_score, p2_score, tie_cnt, inv_cnt, round_cnt,
           match_over, match_winner, match_code, done_pulse
  );
endinterface

// File: rtl/rps_match_scorer.sv
// First-to-WIN_TARGET stone-paper-scissors match scorer, capped at MAX_ROUNDS rounds.
// Consumes judge result bytes over valid/ready and reports the match winner in ASCII.
module rps_match_scorer #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 15,
  parameter int SCORE_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rps_match_scorer_if.slave    sc_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
  localparam logic [7:0]         MAX_R = 8'(MAX_ROUNDS);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic [7:0]         tie_q, tie_d;
  logic [7:0]         inv_q, inv_d;
  logic [7:0]         rnd_q, rnd_d;
  logic [1:0]         win_q, win_d;
  logic               pulse_q, pulse_d;
  logic               accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] win_code(input logic [1:0] w);
    case (w)
      2'b01:   return 8'd49;
      2'b10:   return 8'd50;
      default: return 8'd68;
    endcase
  endfunction

  assign accept = (state_q == S_PLAY) && sc_if.result_valid;

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    tie_d   = tie_q;
    inv_d   = inv_q;
    rnd_d   = rnd_q;
    win_d   = win_q;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (sc_if.start) begin
          p1_d    = '0;
          p2_d    = '0;
          tie_d   = 8'd0;
          inv_d   = 8'd0;
          rnd_d   = 8'd0;
          win_d   = 2'b00;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (accept) begin
          rnd_d = rnd_q + 8'd1;
          case (sc_if.result)
            8'd49:   p1_d  = p1_q + SCORE_W'(1);
            8'd50:   p2_d  = p2_q + SCORE_W'(1);
            8'd0:    tie_d = sat_inc8(tie_q);
            default: inv_d = sat_inc8(inv_q);
          endcase
          // Match end is judged on the post-increment values of this same round.
          if (p1_d == WIN_T) begin
            win_d   = 2'b01;
            state_d = S_DONE;
            pulse_d = 1'b1;
          end else if (p2_d == WIN_T) begin
            win_d   = 2'b10;
            state_d = S_DONE;
            pulse_d = 1'b1;
          end else if (rnd_d == MAX_R) begin
            win_d   = (p1_d > p2_d) ? 2'b01 : (p2_d > p1_d) ? 2'b10 : 2'b00;
            state_d = S_DONE;
            pulse_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      tie_q   <= 8'd0;
      inv_q   <= 8'd0;
      rnd_q   <= 8'd0;
      win_q   <= 2'b00;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      tie_q   <= tie_d;
      inv_q   <= inv_d;
      rnd_q   <= rnd_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
    end
  end

  assign sc_if.result_ready = (state_q == S_PLAY);
  assign sc_if.p1_score     = p1_q;
  assign sc_if.p2_score     = p2_q;
  assign sc_if.tie_cnt      = tie_q;
  assign sc_if.inv_cnt      = inv_q;
  assign sc_if.round_cnt    = rnd_q;
  assign sc_if.match_over   = (state_q == S_DONE);
  assign sc_if.match_winner = (state_q == S_DONE) ? win_q : 2'b00;
  assign sc_if.match_code   = (state_q == S_DONE) ? win_code(win_q) : 8'd0;
  assign sc_if.done_pulse   = pulse_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer: three parameterisations share one stimulus stream,
// checked by hand-written vectors, corner sequences and a per-cycle behavioural model.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rv;
  logic [7:0] res;

  always #5 clk = ~clk;

  rps_match_scorer_if #(.SCORE_W(4)) ifa ();
  rps_match_scorer_if #(.SCORE_W(4)) ifb ();
  rps_match_scorer_if #(.SCORE_W(4)) ifc ();

  assign ifa.start = start;  assign ifa.result_valid = rv;  assign ifa.result = res;
  assign ifb.start = start;  assign ifb.result_valid = rv;  assign ifb.result = res;
  assign ifc.start = start;  assign ifc.result_valid = rv;  assign ifc.result = res;

  rps_match_scorer #(.WIN_TARGET(3),  .MAX_ROUNDS(15),  .SCORE_W(4)) dut_a (.clk(clk), .rst(rst), .sc_if(ifa));
  rps_match_scorer #(.WIN_TARGET(3),  .MAX_ROUNDS(4),   .SCORE_W(4)) dut_b (.clk(clk), .rst(rst), .sc_if(ifb));
  rps_match_scorer #(.WIN_TARGET(15), .MAX_ROUNDS(255), .SCORE_W(4)) dut_c (.clk(clk), .rst(rst), .sc_if(ifc));

  logic [44:0] obs [3];
  assign obs[0] = {ifa.result_ready, ifa.p1_score, ifa.p2_score, ifa.tie_cnt, ifa.inv_cnt, ifa.round_cnt,
                   ifa.match_over, ifa.match_winner, ifa.match_code, ifa.done_pulse};
  assign obs[1] = {ifb.result_ready, ifb.p1_score, ifb.p2_score, ifb.tie_cnt, ifb.inv_cnt, ifb.round_cnt,
                   ifb.match_over, ifb.match_winner, ifb.match_code, ifb.done_pulse};
  assign obs[2] = {ifc.result_ready, ifc.p1_score, ifc.p2_score, ifc.tie_cnt, ifc.inv_cnt, ifc.round_cnt,
                   ifc.match_over, ifc.match_winner, ifc.match_code, ifc.done_pulse};

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = waiting, 1 = playing, 2 = finished.
  typedef struct {
    int phase;
    int p1, p2, tie, inv, rnd, win;
    bit pulse;
  } mdl_t;

  mdl_t m [3];
  int   wt [3] = '{3, 3, 15};
  int   mr [3] = '{15, 4, 255};

  function automatic mdl_t mstep(mdl_t cur, int w_t, int m_r, bit r, bit s, bit v, logic [7:0] x);
    mdl_t n;
    n = cur;
    n.pulse = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (cur.phase != 1) begin
      if (s) begin
        n = '{default: 0};
        n.phase = 1;
      end
    end else if (v) begin
      n.rnd = cur.rnd + 1;
      if (x == 8'd49)      n.p1 = cur.p1 + 1;
      else if (x == 8'd50) n.p2 = cur.p2 + 1;
      else if (x == 8'd0)  n.tie = (cur.tie < 255) ? cur.tie + 1 : 255;
      else                 n.inv = (cur.inv < 255) ? cur.inv + 1 : 255;
      if (n.p1 == w_t || n.p2 == w_t || n.rnd == m_r) begin
        n.phase = 2;
        n.pulse = 1'b1;
        if (n.p1 == w_t)      n.win = 1;
        else if (n.p2 == w_t) n.win = 2;
        else                  n.win = (n.p1 > n.p2) ? 1 : (n.p2 > n.p1) ? 2 : 0;
      end
    end
    return n;
  endfunction

  function automatic logic [44:0] mexp(mdl_t e);
    logic [1:0] w;
    logic [7:0] code;
    w    = 2'b00;
    code = 8'd0;
    if (e.phase == 2) begin
      w    = 2'(e.win);
      code = (e.win == 1) ? 8'd49 : (e.win == 2) ? 8'd50 : 8'd68;
    end
    return {(e.phase == 1), 4'(e.p1), 4'(e.p2), 8'(e.tie), 8'(e.inv), 8'(e.rnd),
            (e.phase == 2), w, code, e.pulse};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input logic [7:0] x);
    rst = r; start = s; rv = v; res = x;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], wt[i], mr[i], r, s, v, x);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== mexp(m[i])) begin
        bad++;
        $display("FAIL model_dut%0d actual=%h required=%h at %0t", i, obs[i], mexp(m[i]), $time);
      end
    end
  endtask

  typedef struct {
    bit r, s, v;
    logic [7:0] x;
    int p1, p2, tie, inv, rnd, over, win, code, pulse, rdy;
  } vec_t;

  vec_t tbl [$];

  initial begin
    rst = 1'b1; start = 1'b0; rv = 1'b0; res = 8'd0;
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};

    //                 r  s  v  x       p1 p2 t  i  rnd ov w  code pl rdy
    tbl.push_back('{1, 0, 0, 8'd0,   0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{0, 1, 0, 8'd0,   0, 0, 0, 0, 0, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd49,  1, 0, 0, 0, 1, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd49,  2, 0, 0, 0, 2, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd49,  3, 0, 0, 0, 3, 1, 1, 49, 1, 0});
    tbl.push_back('{0, 0, 1, 8'd49,  3, 0, 0, 0, 3, 1, 1, 49, 0, 0});
    tbl.push_back('{0, 1, 1, 8'd50,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd50,  0, 1, 0, 0, 1, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd0,   0, 1, 1, 0, 2, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd63,  0, 1, 1, 1, 3, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 1, 1, 8'd7,   0, 1, 1, 2, 4, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd50,  0, 2, 1, 2, 5, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd50,  0, 3, 1, 2, 6, 1, 2, 50, 1, 0});
    tbl.push_back('{0, 0, 0, 8'd0,   0, 3, 1, 2, 6, 1, 2, 50, 0, 0});
    tbl.push_back('{0, 1, 0, 8'd0,   0, 0, 0, 0, 0, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd49,  1, 0, 0, 0, 1, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd49,  2, 0, 0, 0, 2, 0, 0, 0,  0, 1});
    tbl.push_back('{0, 0, 1, 8'd50,  2, 1, 0, 0, 3, 0, 0, 0,  0, 1});
    tbl.push_back('{1, 0, 1, 8'd49,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{0, 0, 1, 8'd49,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{0, 1, 1, 8'd49,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1});
    tbl.push_back('{1, 1, 0, 8'd0,   0, 0, 0, 0, 0, 0, 0, 0,  0, 0});

    foreach (tbl[k]) begin
      cycle(tbl[k].r, tbl[k].s, tbl[k].v, tbl[k].x);
      chk($sformatf("v%0d_p1", k),    int'(ifa.p1_score),     tbl[k].p1);
      chk($sformatf("v%0d_p2", k),    int'(ifa.p2_score),     tbl[k].p2);
      chk($sformatf("v%0d_tie", k),   int'(ifa.tie_cnt),      tbl[k].tie);
      chk($sformatf("v%0d_inv", k),   int'(ifa.inv_cnt),      tbl[k].inv);
      chk($sformatf("v%0d_round", k), int'(ifa.round_cnt),    tbl[k].rnd);
      chk($sformatf("v%0d_over", k),  int'(ifa.match_over),   tbl[k].over);
      chk($sformatf("v%0d_win", k),   int'(ifa.match_winner), tbl[k].win);
      chk($sformatf("v%0d_code", k),  int'(ifa.match_code),   tbl[k].code);
      chk($sformatf("v%0d_pulse", k), int'(ifa.done_pulse),   tbl[k].pulse);
      chk($sformatf("v%0d_ready", k), int'(ifa.result_ready), tbl[k].rdy);
    end

    // Round cap reached with level scores on the short-match instance.
    cycle(1, 0, 0, 8'd0);
    cycle(0, 1, 0, 8'd0);
    cycle(0, 0, 1, 8'd49);
    cycle(0, 0, 1, 8'd50);
    cycle(0, 0, 1, 8'd0);
    chk("cap_not_yet_over", int'(ifb.match_over), 0);
    chk("cap_ready_before", int'(ifb.result_ready), 1);
    cycle(0, 0, 1, 8'd0);
    chk("cap_over",  int'(ifb.match_over),   1);
    chk("cap_round", int'(ifb.round_cnt),    4);
    chk("cap_win",   int'(ifb.match_winner), 0);
    chk("cap_code",  int'(ifb.match_code),   68);
    chk("cap_pulse", int'(ifb.done_pulse),   1);
    chk("cap_ready", int'(ifb.result_ready), 0);
    cycle(0, 0, 1, 8'd49);
    chk("cap_pulse_gone", int'(ifb.done_pulse), 0);
    chk("cap_hold_round", int'(ifb.round_cnt),  4);

    // 255-round drawn match alternating tie and invalid.
    cycle(1, 0, 0, 8'd0);
    cycle(0, 1, 0, 8'd0);
    for (int k = 0; k < 255; k++) begin
      cycle(0, 0, 1, (k % 2 == 1) ? 8'd63 : 8'd0);
      if (k == 253) chk("long_not_over", int'(ifc.match_over), 0);
    end
    chk("long_tie",   int'(ifc.tie_cnt),      128);
    chk("long_inv",   int'(ifc.inv_cnt),      127);
    chk("long_round", int'(ifc.round_cnt),    255);
    chk("long_over",  int'(ifc.match_over),   1);
    chk("long_win",   int'(ifc.match_winner), 0);
    chk("long_code",  int'(ifc.match_code),   68);
    cycle(0, 0, 1, 8'd0);
    chk("long_hold_tie", int'(ifc.tie_cnt), 128);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] x;
      case ($urandom_range(0, 4))
        0:       x = 8'd0;
        1:       x = 8'd49;
        2:       x = 8'd50;
        3:       x = 8'd63;
        default: x = 8'($urandom);
      endcase
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
